// File: rtl/slave.sv
// Two-wire serial link receiver.
// The bus lines are oversampled on clk, START/STOP and scl rising edges are
// decoded, and MESSAGE_LENGTH bits (LSB first) are assembled into a word
// that is presented with a one-cycle data_valid strobe.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | bus idle or frame abandoned; waits for START
// ST_RECEIVE   | START seen; collecting data bits on scl rising edges
// ST_WAIT_STOP | full word delivered; expects STOP (or a new START)
module slave #(
    parameter int MESSAGE_LENGTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sda,
    input  logic                      scl,
    output logic [MESSAGE_LENGTH-1:0] data,
    output logic                      data_valid,
    output logic                      frame_error,
    output logic                      busy
);

    localparam int CW = $clog2(MESSAGE_LENGTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MESSAGE_LENGTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MESSAGE_LENGTH);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RECEIVE   = 2'd1;
    localparam logic [1:0] ST_WAIT_STOP = 2'd2;

    logic sda_s1_q, sda_s2_q, sda_s3_q;
    logic scl_s1_q, scl_s2_q, scl_s3_q;

    logic [1:0]                state_q, state_d;
    logic [CW-1:0]             bit_count_q, bit_count_d;
    logic [MESSAGE_LENGTH-1:0] shift_q, shift_d;
    logic [MESSAGE_LENGTH-1:0] data_q, data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      frame_error_q, frame_error_d;
    logic                      busy_q, busy_d;

    logic                      start_evt, stop_evt, sample_evt;
    logic [MESSAGE_LENGTH-1:0] shift_ins;

    // Three-stage capture of both lines; idle bus is high, so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_s3_q <= 1'b1;
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_s3_q <= 1'b1;
        end else begin
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_s3_q <= sda_s2_q;
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_s3_q <= scl_s2_q;
        end
    end

    // START/STOP need scl stable high across both samples, so an sda change
    // coincident with an scl edge is seen only as the scl edge.
    assign start_evt  = scl_s2_q & scl_s3_q & sda_s3_q & ~sda_s2_q;
    assign stop_evt   = scl_s2_q & scl_s3_q & ~sda_s3_q & sda_s2_q;
    assign sample_evt = scl_s2_q & ~scl_s3_q;

    // Shift register with the current sda sample dropped into slot bit_count.
    always_comb begin
        shift_ins = shift_q;
        for (int i = 0; i < MESSAGE_LENGTH; i++) begin
            if (bit_count_q == CW'(i)) begin
                shift_ins[i] = sda_s2_q;
            end
        end
    end

    // Frame sequencing: next state, bit counter, word assembly and strobes.
    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    state_d     = ST_RECEIVE;
                    bit_count_d = '0;
                    shift_d     = '0;
                    busy_d      = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (start_evt) begin
                    bit_count_d = '0;
                    shift_d     = '0;
                end else if (stop_evt) begin
                    frame_error_d = 1'b1;
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    bit_count_d   = '0;
                end else if (sample_evt) begin
                    shift_d = shift_ins;
                    if (bit_count_q == LAST_IDX) begin
                        data_d       = shift_ins;
                        data_valid_d = 1'b1;
                        state_d      = ST_WAIT_STOP;
                        bit_count_d  = FULL_CNT;
                    end else begin
                        bit_count_d = bit_count_q + CW'(1);
                    end
                end
            end
            ST_WAIT_STOP: begin
                if (stop_evt) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    bit_count_d = '0;
                end else if (start_evt) begin
                    state_d     = ST_RECEIVE;
                    bit_count_d = '0;
                    shift_d     = '0;
                end else if (sample_evt) begin
                    frame_error_d = 1'b1;
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    bit_count_d   = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                bit_count_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_count_q   <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_slave.sv
// Bench for slave: bus-level stimulus tasks log the line events they create,
// and a frame-level reference turns that event log into expected outputs.
module tb_slave;

    localparam int ML     = 8;
    localparam int EV_ERR = 256;
    localparam int SYM_START = 0;
    localparam int SYM_STOP  = 1;
    localparam int SYM_S0    = 2;   // sample of a 0; SYM_S0 + 1 = sample of a 1

    logic          clk;
    logic          rst;
    logic          sda;
    logic          scl;
    logic [ML-1:0] data;
    logic          data_valid;
    logic          frame_error;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;

    int sym_q[$];
    int ev_q[$];
    int exp_q[$];
    int seg_bits[$];

    typedef struct {
        string         name;
        int            nbits;
        logic [15:0]   bits;
        int            exp_valid;
        int            exp_err;
        logic [ML-1:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    slave #(.MESSAGE_LENGTH(ML)) dut (
        .clk         (clk),
        .rst         (rst),
        .sda         (sda),
        .scl         (scl),
        .data        (data),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Record every strobe the DUT produces.
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_error)) begin
            check("dv_fe_exclusive", {31'b0, data_valid & frame_error}, 32'd0);
            if (data_valid) begin
                ev_q.push_back(int'(data));
                dv_cnt++;
            end
            if (frame_error) begin
                ev_q.push_back(EV_ERR);
                fe_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bus primitives (each logs what it causes) ----------
    task automatic step();
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic set_scl(input logic v);
        if (v && !scl) sym_q.push_back(SYM_S0 + int'(sda));
        scl = v;
        step();
    endtask

    task automatic set_sda(input logic v);
        if (scl && sda && !v) sym_q.push_back(SYM_START);
        if (scl && !sda && v) sym_q.push_back(SYM_STOP);
        sda = v;
        step();
    endtask

    task automatic set_both(input logic vscl, input logic vsda);
        if (vscl && !scl) sym_q.push_back(SYM_S0 + int'(vsda));
        else if (vscl && scl && sda && !vsda) sym_q.push_back(SYM_START);
        else if (vscl && scl && !sda && vsda) sym_q.push_back(SYM_STOP);
        scl = vscl;
        sda = vsda;
        step();
    endtask

    // Bits leave scl high so a following START (after a 1) or STOP (after
    // a 0) needs no further scl rise.
    task automatic send_bit(input logic b);
        if (scl) set_scl(1'b0);
        set_sda(b);
        set_scl(1'b1);
    endtask

    task automatic glitch_bit(input logic b);
        if (scl) set_scl(1'b0);
        set_sda(~b);
        set_sda(b);
        set_sda(~b);
        set_both(1'b1, b);
    endtask

    task automatic send_start();
        if (!sda) begin
            if (scl) set_scl(1'b0);
            set_sda(1'b1);
        end
        if (!scl) set_scl(1'b1);
        set_sda(1'b0);
    endtask

    task automatic send_stop();
        if (sda) begin
            if (scl) set_scl(1'b0);
            set_sda(1'b0);
        end
        if (!scl) set_scl(1'b1);
        set_sda(1'b1);
    endtask

    // ---------------- frame-level reference --------------------------------
    // A frame runs from a START to the next START/STOP. With m samples in it:
    // a word is delivered once m reaches ML (first ML samples, LSB first);
    // an error is flagged if m exceeds ML, or if a STOP ends it short.
    function automatic void close_seg(input bit by_stop);
        int m = seg_bits.size();
        int word = 0;
        if (m >= ML) begin
            for (int i = 0; i < ML; i++) word += seg_bits[i] << i;
            exp_q.push_back(word);
        end
        if (m > ML || (m < ML && by_stop)) exp_q.push_back(EV_ERR);
    endfunction

    function automatic void run_model();
        bit open = 1'b0;
        exp_q.delete();
        seg_bits.delete();
        foreach (sym_q[i]) begin
            if (sym_q[i] == SYM_START) begin
                if (open) close_seg(1'b0);
                open = 1'b1;
                seg_bits.delete();
            end else if (sym_q[i] == SYM_STOP) begin
                if (open) close_seg(1'b1);
                open = 1'b0;
            end else if (open) begin
                seg_bits.push_back(sym_q[i] - SYM_S0);
            end
        end
        if (open) close_seg(1'b0);
    endfunction

    task automatic compare_events(input string tag);
        int n;
        run_model();
        check({tag, "_event_count"}, ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, ev_q[i], exp_q[i]);
        sym_q.delete();
        ev_q.delete();
    endtask

    task automatic clear_logs();
        sym_q.delete();
        ev_q.delete();
        dv_cnt = 0;
        fe_cnt = 0;
    endtask

    // ---------------- test sequence ----------------------------------------
    initial begin
        logic [15:0] w;
        int          last_word;
        int          r;

        vecs[0] = '{"short",   3, 16'h0003, 0, 1, 8'h00};
        vecs[1] = '{"basic",   8, 16'h004D, 1, 0, 8'h4D};
        vecs[2] = '{"extra",   9, 16'h003C, 1, 1, 8'h3C};
        vecs[3] = '{"empty",   0, 16'h0000, 0, 1, 8'h3C};
        vecs[4] = '{"seven",   7, 16'h0025, 0, 1, 8'h3C};

        rst = 1'b1;
        scl = 1'b1;
        sda = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_data", data, 0);
        check("reset_dv", data_valid, 0);
        check("reset_fe", frame_error, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        step();

        // Table of complete frames from an idle bus.
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            send_start();
            check({vecs[v].name, "_busy_start"}, busy, 1);
            for (int i = 0; i < vecs[v].nbits; i++) send_bit(vecs[v].bits[i]);
            send_stop();
            check({vecs[v].name, "_valid_cnt"}, dv_cnt, vecs[v].exp_valid);
            check({vecs[v].name, "_err_cnt"}, fe_cnt, vecs[v].exp_err);
            check({vecs[v].name, "_data"}, data, vecs[v].exp_data);
            check({vecs[v].name, "_busy_end"}, busy, 0);
        end

        // Strobe latency on the last bit of 8'h4D.
        clear_logs();
        w = 16'h004D;
        send_start();
        for (int i = 0; i < ML - 1; i++) send_bit(w[i]);
        set_scl(1'b0);
        set_sda(w[ML-1]);
        sym_q.push_back(SYM_S0 + int'(w[ML-1]));
        scl = 1'b1;
        @(posedge clk); #1;
        check("lat_dv_k", data_valid, 0);
        @(posedge clk); #1;
        check("lat_dv_k1", data_valid, 0);
        @(posedge clk); #1;
        check("lat_dv_k2", data_valid, 1);
        check("lat_data_k2", data, 8'h4D);
        @(posedge clk); #1;
        check("lat_dv_k3", data_valid, 0);
        #1;
        step();
        check("lat_busy_pre_stop", busy, 1);
        send_stop();
        check("lat_busy_post_stop", busy, 0);
        compare_events("latency");

        // Repeated start, then 8'hA5. A word ending in 1 cannot reach STOP
        // without another scl rise, so it chains straight into 8'h4D.
        clear_logs();
        send_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_start();
        w = 16'h00A5;
        for (int i = 0; i < ML; i++) send_bit(w[i]);
        check("rs_after_a5_data", data, 8'hA5);
        check("rs_after_a5_err", fe_cnt, 0);
        send_start();
        w = 16'h004D;
        for (int i = 0; i < ML; i++) send_bit(w[i]);
        send_stop();
        check("rs_valid_cnt", dv_cnt, 2);
        check("rs_err_cnt", fe_cnt, 0);
        compare_events("rep_start");

        // Asynchronous reset after four bits, then a clean 8'hFF frame.
        clear_logs();
        send_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rstmid_data", data, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_dv", data_valid, 0);
        check("rstmid_fe", frame_error, 0);
        scl = 1'b0;
        sda = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        step();
        clear_logs();
        send_start();
        for (int i = 0; i < ML; i++) send_bit(1'b1);
        check("rstmid_ff_data", data, 8'hFF);
        check("rstmid_ff_err", fe_cnt, 0);
        compare_events("rst_mid");

        // sda toggling while scl low, and scl/sda moving in the same sample.
        clear_logs();
        send_start();
        w = 16'h006A;
        for (int i = 0; i < ML; i++) glitch_bit(w[i]);
        check("glitch_busy", busy, 1);
        check("glitch_data", data, 8'h6A);
        send_stop();
        check("glitch_err", fe_cnt, 0);
        check("glitch_busy_end", busy, 0);
        compare_events("glitch");

        // Random bus activity against the frame-level reference.
        clear_logs();
        last_word = int'(data);
        send_start();
        for (int op = 0; op < 150; op++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) send_start();
            else if (r < 26) send_stop();
            else if (r < 34) glitch_bit(1'($urandom_range(0, 1)));
            else send_bit(1'($urandom_range(0, 1)));
        end
        send_stop();
        run_model();
        foreach (exp_q[i]) if (exp_q[i] != EV_ERR) last_word = exp_q[i];
        check("rand_final_data", data, last_word);
        check("rand_final_busy", busy, 0);
        compare_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
